regfile_bist: RTL and testbench
===============================

// Module: regfile_bist
// PURPOSE
//  Built-in self-test initiator for the 32x32 MIPS register file: it drives the
//  write port (RW/BusW/RegWr) and both read ports (RA/RB). It checks BusA/BusB
//  against expected values.
//  Sits beside the register file behind a mux. During test it owns the ports;
//  the datapath owns them otherwise.
//  Runs a two-pass (pattern / inverted pattern) march and reports pass/fail,
//  an error count, and the first failing register.
// PARAMETERS
//  PATTERN   32'h5A5A_C300  pass-0 seed; reg i is written with PATTERN ^ i (i zero-extended)
//  ERR_W     8              width of err_count (saturating)
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   begin a run; sampled in IDLE or DONE only
//  busy         out  1   high while a run is in progress
//  done         out  1   high from run end until next start or reset
//  pass         out  1   valid when done=1; 1 = no mismatches
//  err_count    out  ERR_W  number of mismatching read-port samples, saturates at all-ones
//  first_err_reg out 5   register index of first mismatch (BusA before BusB); 0 if none
//  RA, RB       out  5   register file read addresses
//  RW           out  5   register file write address
//  BusW         out  32  register file write data
//  RegWr        out  1   register file write enable
//  BusA, BusB   in   32  register file read data (combinational from RA/RB)
// BEHAVIOUR
//  Reset (async): state=IDLE, pass index=0, idx=0.
//   All outputs are 0, including RegWr. Register file contents are not restored.
//  Expected value: E(p,i) = (i==0) ? 0 : (p==0 ? PATTERN^i : ~(PATTERN^i)).
//  FSM: IDLE -> WR -> ZWR -> RD -> (p==0 ? WR with p=1 : DONE).
//   IDLE: outputs idle. start=1 -> WR, idx=1, p=0.
//    Also clears err_count, first_err_reg, pass, done.
//   WR (31 cyc): RW=idx, BusW=E(p,idx), RegWr=1, idx 1..31. idx==31 -> ZWR.
//   ZWR (1 cyc): RW=0, BusW=PATTERN (nonzero), RegWr=1. This checks that $0 ignores writes.
//    Then RD, idx=0.
//   RD (16 cyc): RegWr=0, RA=idx, RB=idx+1, idx=0,2,..,30.
//    Compare BusA vs E(p,RA) and BusB vs E(p,RB) in the same cycle.
//    Register the error update on posedge. idx==30 -> next pass or DONE.
//   DONE: busy=0, done=1, pass=(err_count==0).
//    start=1 restarts exactly as from IDLE, with results cleared on the same edge.
//  Timing:
//   - busy rises on the edge that samples start.
//   - A run is 2*(31+1+16)=96 busy cycles.
//   - done rises on the edge ending the last RD cycle; busy falls on that same edge.
//  Write semantics: RW/BusW/RegWr are registered outputs, held stable for the full cycle.
//   The register file commits them by the end of that cycle.
//  Error accounting: each of BusA/BusB counts separately. Both mismatching in one cycle adds 2.
//   The increment saturates at 2^ERR_W-1.
//   first_err_reg latches only on the first mismatch of a run. If both ports mismatch in that
//   cycle, the RA index is taken.
//  start while busy: ignored. No abort input; reset is the only abort.
//  Reset mid-run: immediate return to IDLE, RegWr drops asynchronously, results cleared.
//  RA/RB/RW never exceed 31. idx arithmetic is 5-bit, with no wrap used.
// TESTING
//  1 Good regfile model, start pulse -> busy 96 cycles, then done=1, pass=1, err_count=0,
//    first_err_reg=0.
//  2 Write trace check -> pass0 RW=5 with BusW=32'h5A5AC305; pass1 RW=5 with
//    BusW=32'hA5A53CFA; ZWR has RW=0, BusW=32'h5A5AC300.
//  3 Model with reg7 bit0 stuck-at-0 -> pass0 RD(6,7) mismatches, pass1 matches.
//    Result: done=1, pass=0, err_count=1, first_err_reg=7.
//  4 Model where $0 is writable -> RD RA=0 returns 32'h5A5AC300 in both passes.
//    Result: err_count=2, first_err_reg=0, pass=0.
//  5 Assert reset at busy cycle 40 -> RegWr=0 and busy=0 immediately, done=0.
//    A new start then gives a full 96-cycle run with pass=1.
//  6 start held high across the run and into DONE -> no restart while busy.
//    Restart occurs on the first DONE edge: done low for 96 cycles, then results match scenario 1.

Source files
------------

// File: rtl/regfile_bist_if.sv
// Register-file port bundle shared by the BIST initiator and the register file.
// The master drives the addresses and write port. The slave returns the combinational read data.
interface regfile_bist_if;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        RegWr;
  logic [31:0] BusA;
  logic [31:0] BusB;

  modport master (output RA, RB, RW, BusW, RegWr, input BusA, BusB);
  modport slave  (input RA, RB, RW, BusW, RegWr, output BusA, BusB);
endinterface

// File: rtl/regfile_bist.sv
// Two-pass march BIST for the 32x32 register file: write all, read pairs, then repeat inverted.
// All outputs are registered. They are computed from the next state so each one is stable for a whole cycle.
module regfile_bist #(
  parameter logic [31:0] PATTERN = 32'h5A5A_C300,
  parameter int          ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  // start is sampled only in IDLE/DONE; busy rises on the sampling edge and
  // done rises on the edge where busy falls, staying high until the next start.
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       first_err_reg,
  regfile_bist_if.master   rf,
  output logic [2:0]       dbgState
);

  typedef enum logic [2:0] {IDLE, WR, ZWR, RD, DONE} stateT;

  stateT      state, stateNext;
  logic [4:0] idx, idxNext;
  logic       pCur, pNext;
  logic       clearRes;
  logic       seenErr, seenNext;

  function automatic logic [31:0] expVal(input logic p, input logic [4:0] i);
    logic [31:0] v;
    v = PATTERN ^ {27'd0, i};
    if (i == 5'd0) return 32'd0;
    return p ? ~v : v;
  endfunction

  assign dbgState = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 5'd0;
      pCur  <= 1'b0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      pCur  <= pNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    pNext     = pCur;
    clearRes  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        stateNext = WR;
        idxNext   = 5'd1;
        pNext     = 1'b0;
        clearRes  = 1'b1;
      end
      WR: begin
        if (idx == 5'd31) stateNext = ZWR;
        else              idxNext   = idx + 5'd1;
      end
      ZWR: begin
        stateNext = RD;
        idxNext   = 5'd0;
      end
      RD: begin
        if (idx == 5'd30) begin
          if (!pCur) begin
            stateNext = WR;
            idxNext   = 5'd1;
            pNext     = 1'b1;
          end else begin
            stateNext = DONE;
          end
        end else begin
          idxNext = idx + 5'd2;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Read checking: both ports are compared in the same RD cycle.
  logic             misA, misB;
  logic [1:0]       errInc;
  logic [ERR_W:0]   errSum;
  logic [ERR_W-1:0] errNext;
  logic [4:0]       firstNext;
  logic             busyNext, doneNext, passNext;
  logic [4:0]       raNext, rbNext, rwNext;
  logic [31:0]      busWNext;
  logic             regWrNext;

  always_comb begin
    misA   = (state == RD) && (rf.BusA != expVal(pCur, idx));
    misB   = (state == RD) && (rf.BusB != expVal(pCur, idx + 5'd1));
    errInc = {1'b0, misA} + {1'b0, misB};
    errSum = {1'b0, err_count} + {{(ERR_W-1){1'b0}}, errInc};
    errNext   = errSum[ERR_W] ? {ERR_W{1'b1}} : errSum[ERR_W-1:0];
    firstNext = first_err_reg;
    seenNext  = seenErr;
    if (!seenErr && misA) begin
      firstNext = idx;
      seenNext  = 1'b1;
    end else if (!seenErr && misB) begin
      firstNext = idx + 5'd1;
      seenNext  = 1'b1;
    end
    if (clearRes) begin
      errNext   = '0;
      firstNext = 5'd0;
      seenNext  = 1'b0;
    end
    busyNext  = (stateNext == WR) || (stateNext == ZWR) || (stateNext == RD);
    doneNext  = (stateNext == DONE);
    passNext  = doneNext && (errNext == '0);
    raNext    = 5'd0;
    rbNext    = 5'd0;
    rwNext    = 5'd0;
    busWNext  = 32'd0;
    regWrNext = 1'b0;
    case (stateNext)
      WR: begin
        rwNext    = idxNext;
        busWNext  = expVal(pNext, idxNext);
        regWrNext = 1'b1;
      end
      ZWR: begin
        busWNext  = PATTERN;
        regWrNext = 1'b1;
      end
      RD: begin
        raNext = idxNext;
        rbNext = idxNext + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_reg <= 5'd0;
      seenErr       <= 1'b0;
      rf.RA         <= 5'd0;
      rf.RB         <= 5'd0;
      rf.RW         <= 5'd0;
      rf.BusW       <= 32'd0;
      rf.RegWr      <= 1'b0;
    end else begin
      busy          <= busyNext;
      done          <= doneNext;
      pass          <= passNext;
      err_count     <= errNext;
      first_err_reg <= firstNext;
      seenErr       <= seenNext;
      rf.RA         <= raNext;
      rf.RB         <= rbNext;
      rf.RW         <= rwNext;
      rf.BusW       <= busWNext;
      rf.RegWr      <= regWrNext;
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural register file with fault knobs and scoreboarded write/read traces.
// Result checks are made after each run.
module tb_regfile_bist;
  localparam logic [31:0] PATTERN = 32'h5A5A_C300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [7:0] errCount;
  logic [4:0] firstErr;
  logic [2:0] dbgState;

  regfile_bist_if rf();

  regfile_bist dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (errCount),
    .first_err_reg (firstErr),
    .rf            (rf),
    .dbgState      (dbgState)
  );

  always #5 clk = ~clk;

  // Register file model with fault knobs.
  logic [31:0] mem [32];
  logic        zeroWr = 1'b0;
  logic        stuck7 = 1'b0;

  always @(posedge clk)
    if (rf.RegWr && (rf.RW != 5'd0 || zeroWr)) mem[rf.RW] <= rf.BusW;

  always_comb begin
    rf.BusA = mem[rf.RA];
    rf.BusB = mem[rf.RB];
    if (rf.RA == 5'd0 && !zeroWr) rf.BusA = 32'd0;
    if (rf.RB == 5'd0 && !zeroWr) rf.BusB = 32'd0;
    if (stuck7 && rf.RA == 5'd7) rf.BusA[0] = 1'b0;
    if (stuck7 && rf.RB == 5'd7) rf.BusB[0] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  logic [36:0] wr_q[$];
  logic [9:0]  rd_q[$];
  logic [31:0] w5 [2];
  int          nW5 = 0;
  logic [31:0] zwrData = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expv(input int p, input int i);
    logic [31:0] v;
    if (i == 0) return 32'd0;
    v = PATTERN ^ 32'(i);
    return (p != 0) ? ~v : v;
  endfunction

  // Monitor: every write and every read-address pair is popped from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rf.RegWr) begin
        if (rf.RW == 5'd5) begin
          if (nW5 < 2) w5[nW5] = rf.BusW;
          nW5++;
        end
        if (rf.RW == 5'd0) zwrData = rf.BusW;
        if (wr_q.size() == 0) check("wr_extra", 64'(wr_q.size()), 64'd1);
        else check("wr_trace", {rf.RW, rf.BusW}, wr_q.pop_front());
      end else if (busy) begin
        if (rd_q.size() == 0) check("rd_extra", 64'(rd_q.size()), 64'd1);
        else check("rd_trace", {rf.RA, rf.RB}, rd_q.pop_front());
      end
    end
  end

  task automatic push_run();
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i < 32; i++) wr_q.push_back({5'(i), expv(p, i)});
      wr_q.push_back({5'd0, PATTERN});
      for (int i = 0; i <= 30; i += 2) rd_q.push_back({5'(i), 5'(i + 1)});
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_results(input int expErr, input int expFirst, input logic expPass);
    check("done", done, 1);
    check("pass", pass, expPass);
    check("err_count", errCount, expErr);
    check("first_err_reg", firstErr, expFirst);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
  endtask

  task automatic run_once(input int expErr, input int expFirst, input logic expPass);
    int n;
    push_run();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(n);
    check("busy_cycles", n, 96);
    check_results(expErr, expFirst, expPass);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wr_q.delete();
    rd_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic abort_at(input int cyc, input logic expWrBefore);
    push_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (cyc - 1) @(negedge clk);
    check("busy_before_abort", busy, 1);
    check("regwr_before_abort", rf.RegWr, expWrBefore);
    reset = 1'b1;
    #1;
    check("abort_regwr", rf.RegWr, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", errCount, 0);
    do_reset();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'd0;
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_regwr", rf.RegWr, 0);
    check("rst_bus", {rf.RA, rf.RB, rf.RW, rf.BusW}, 0);
    check("rst_dbg_state", dbgState, 0);
    do_reset();

    // Good register file, plus write-trace spot values
    nW5 = 0;
    run_once(0, 0, 1'b1);
    check("w5_pass0", w5[0], 32'h5A5AC305);
    check("w5_pass1", w5[1], 32'hA5A53CFA);
    check("zwr_data", zwrData, 32'h5A5AC300);

    // reg7 bit0 stuck-at-0
    stuck7 = 1'b1;
    run_once(1, 7, 1'b0);
    stuck7 = 1'b0;

    // $0 writable
    zeroWr = 1'b1;
    run_once(2, 0, 1'b0);
    zeroWr = 1'b0;

    // Reset mid-run: in RD (cycle 40) and in WR (cycle 10), then a clean run
    abort_at(40, 1'b0);
    abort_at(10, 1'b1);
    run_once(0, 0, 1'b1);

    // start held high across the run and into DONE
    push_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_busy(n);
    check("hold_busy_cycles", n, 96);
    check("hold_done", done, 1);
    check("hold_pass", pass, 1);
    push_run();
    @(negedge clk);
    check("restart_done_low", done, 0);
    check("restart_busy", busy, 1);
    start = 1'b0;
    wait_busy(n);
    check("restart_busy_cycles", n, 96);
    check_results(0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
